keypad_scan_ctrl: RTL and testbench
===================================

// Module: keypad_scan_ctrl
// PURPOSE
//   Parametrised ROWS x COLS matrix-keypad scanner and debouncer; next-generation replacement
//   for the fixed 4x4 scanner. Drives active-low columns, samples active-low rows and emits
//   a binary key code with a one-cycle valid strobe. Adds counted debounce, release detection,
//   multi-key rejection and optional auto-repeat. Feeds the amount/charge control logic.
//   Runs on a clock-enable tick, not a derived clock.
// PARAMETERS
//   ROWS            4      number of row inputs (>=2)
//   COLS            4      number of column drives (>=2)
//   TICK_DIV        20000  clk cycles per scan tick (50 MHz -> 2500 Hz); >=2
//   DEBOUNCE_TICKS  4      consecutive identical samples to accept a press or a release; >=1
//   REPEAT_TICKS    0      ticks between auto-repeat strobes while held; 0 disables repeat
//   CW              $clog2(ROWS*COLS)  key code width (localparam)
// PORTS
//   clk          in   1     system clock
//   rst_n        in   1     asynchronous reset, active low
//   row          in   ROWS  keypad rows, low = pressed (asynchronous; synchronised internally)
//   col          out  COLS  column drive, low = driven/selected
//   key_code     out  CW    code of last accepted key = row_idx*COLS + col_idx (bit index)
//   key_valid    out  1     one-cycle strobe: new press accepted, or auto-repeat
//   key_held     out  1     level: an accepted key is currently held
//   key_release  out  1     one-cycle strobe: held key released (debounced)
//   multi_key    out  1     one-cycle strobe: >1 row low in the selected column; press discarded
// BEHAVIOUR
//   Reset: col=0 (all driven), key_code=0, key_valid=key_held=key_release=multi_key=0,
//     state IDLE, all counters 0. Reset is honoured in any state, mid-debounce included.
//   row passes a 2-flop synchroniser; every FSM decision uses the synchronised value.
//   Tick: counter 0..TICK_DIV-1; tick=1 for one clk when counter==TICK_DIV-1; counter wraps.
//   State changes and sampling happen only on tick cycles. Outputs are registered.
//   IDLE:     col=all 0. On tick with any row low -> SCAN, col_idx=0.
//   SCAN:     col=~(1<<col_idx). On tick: zero rows low -> col_idx+1; from COLS-1 -> IDLE.
//             Exactly one row low -> latch row_idx/col_idx, deb_cnt=1, -> DEBOUNCE
//             (DEBOUNCE_TICKS==1: accept immediately, -> HELD).
//             More than one row low -> multi_key strobe, -> IDLE.
//   DEBOUNCE: same col held. On tick: same single row low -> deb_cnt+1; at DEBOUNCE_TICKS
//             -> key_code updated, key_valid strobe, -> HELD, rep_cnt=0.
//             Any other pattern -> IDLE, no strobe, key_code unchanged.
//   HELD:     key_held=1, same col held. On tick: same row low -> rep_cnt+1; if REPEAT_TICKS!=0
//             and rep_cnt reaches REPEAT_TICKS -> key_valid strobe, rep_cnt=0.
//             Row pattern all high -> deb_cnt=1, -> RELEASE. Extra row low -> multi_key strobe,
//             stay HELD, no repeat on that tick.
//   RELEASE:  key_held stays 1. On tick: all high -> deb_cnt+1; at DEBOUNCE_TICKS -> key_release
//             strobe, key_held=0, -> IDLE. Same key low again -> HELD, rep_cnt=0, no new key_valid.
//   Latency: key_valid rises the clk cycle after the tick carrying the final debounce sample.
//   Strobes never coincide: key_valid/key_release/multi_key are mutually exclusive per cycle.
//   key_code is stable from its key_valid strobe until the next accepted press.
//   Column settling: a column is driven for one full tick before it is sampled.
// TESTING (TICK_DIV=4, DEBOUNCE_TICKS=3, ROWS=COLS=4 unless noted)
//   Reset: rst_n=0 mid-DEBOUNCE -> col=4'b0000, all strobes 0, key_held=0, key_code=0 at once.
//   Clean press row[1] on col[2] held 20 ticks -> one key_valid, key_code=6, key_held=1;
//     release -> key_release exactly 3 ticks after rows go high, then IDLE.
//   Bounce: press held only 2 ticks (< 3) -> no key_valid, key_code unchanged, back to IDLE.
//   Two rows (row[0],row[3]) low on col[1] -> one multi_key strobe, no key_valid.
//   REPEAT_TICKS=5, key 15 held 23 ticks after accept -> key_valid at accept +4 repeats, code=15.
//   Release glitch: 1-tick high then low again while HELD -> no key_release, no extra key_valid.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: drives active-low columns, debounces active-low rows and reports
// key codes with press, repeat, release and multi-key strobes, all paced by a scan tick.
module keypad_scan_ctrl #(
  parameter int ROWS           = 4,
  parameter int COLS           = 4,
  parameter int TICK_DIV       = 20000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int REPEAT_TICKS   = 0,
  localparam int CW            = $clog2(ROWS*COLS)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [ROWS-1:0] row,
  output logic [COLS-1:0] col,
  output logic [CW-1:0]   key_code,
  output logic            key_valid,
  output logic            key_held,
  output logic            key_release,
  output logic            multi_key
);

  localparam int DW  = $clog2(TICK_DIV);
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CIW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int NW  = $clog2(ROWS + 1);
  localparam int DBW = $clog2(DEBOUNCE_TICKS + 1);
  localparam int RPW = (REPEAT_TICKS > 0) ? $clog2(REPEAT_TICKS + 1) : 1;
  localparam logic [ROWS-1:0] ROW_ONE = ROWS'(1);
  localparam logic [COLS-1:0] COL_ONE = COLS'(1);

  typedef enum logic [2:0] {IDLE, SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  state_t          state_q, state_d;
  logic [ROWS-1:0] row_meta_q, row_sync_q;
  logic [DW-1:0]   div_q, div_d;
  logic            tick;
  logic [CIW-1:0]  col_idx_q, col_idx_d;
  logic [RW-1:0]   row_idx_q, row_idx_d;
  logic [DBW-1:0]  deb_q, deb_d;
  logic [RPW-1:0]  rep_q, rep_d;
  logic [CW-1:0]   key_code_q, key_code_d;
  logic            valid_q, valid_d, held_q, held_d;
  logic            release_q, release_d, multi_q, multi_d;
  logic [COLS-1:0] col_q, col_d;

  logic [ROWS-1:0] low;
  logic [NW-1:0]   n_low;
  logic [RW-1:0]   low_idx;
  logic            own_only;

  function automatic logic [CW-1:0] code_of(input logic [RW-1:0] r, input logic [CIW-1:0] c);
    return CW'(r) * CW'(COLS) + CW'(c);
  endfunction

  assign tick  = (div_q == DW'(TICK_DIV - 1));
  assign div_d = tick ? '0 : div_q + DW'(1);

  always_comb begin
    low      = ~row_sync_q;
    n_low    = '0;
    low_idx  = '0;
    for (int i = 0; i < ROWS; i++) begin
      if (low[i]) begin
        n_low   = n_low + NW'(1);
        low_idx = RW'(i);
      end
    end
    own_only = (low == (ROW_ONE << row_idx_q));
  end

  always_comb begin
    state_d    = state_q;
    col_idx_d  = col_idx_q;
    row_idx_d  = row_idx_q;
    deb_d      = deb_q;
    rep_d      = rep_q;
    key_code_d = key_code_q;
    valid_d    = 1'b0;
    release_d  = 1'b0;
    multi_d    = 1'b0;
    if (tick) begin
      case (state_q)
        IDLE: begin
          if (n_low != '0) begin
            state_d   = SCAN;
            col_idx_d = '0;
          end
        end
        SCAN: begin
          if (n_low == '0) begin
            if (col_idx_q == CIW'(COLS - 1)) state_d = IDLE;
            else                             col_idx_d = col_idx_q + CIW'(1);
          end else if (n_low == NW'(1)) begin
            row_idx_d = low_idx;
            deb_d     = DBW'(1);
            if (DEBOUNCE_TICKS == 1) begin
              key_code_d = code_of(low_idx, col_idx_q);
              valid_d    = 1'b1;
              rep_d      = '0;
              state_d    = HELD;
            end else begin
              state_d = DEBOUNCE;
            end
          end else begin
            multi_d = 1'b1;
            state_d = IDLE;
          end
        end
        DEBOUNCE: begin
          if (own_only) begin
            deb_d = deb_q + DBW'(1);
            if (deb_d == DBW'(DEBOUNCE_TICKS)) begin
              key_code_d = code_of(row_idx_q, col_idx_q);
              valid_d    = 1'b1;
              rep_d      = '0;
              state_d    = HELD;
            end
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (own_only) begin
            if (REPEAT_TICKS != 0) begin
              rep_d = rep_q + RPW'(1);
              if (rep_d == RPW'(REPEAT_TICKS)) begin
                valid_d = 1'b1;
                rep_d   = '0;
              end
            end
          end else if (low[row_idx_q]) begin
            multi_d = 1'b1;
          end else begin
            // Our row went high: this tick is the first release sample.
            deb_d = DBW'(1);
            if (DEBOUNCE_TICKS == 1) begin
              release_d = 1'b1;
              state_d   = IDLE;
            end else begin
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (n_low == '0) begin
            deb_d = deb_q + DBW'(1);
            if (deb_d == DBW'(DEBOUNCE_TICKS)) begin
              release_d = 1'b1;
              state_d   = IDLE;
            end
          end else if (own_only) begin
            rep_d   = '0;
            state_d = HELD;
          end else begin
            deb_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    held_d = (state_d == HELD) || (state_d == RELEASE);
    col_d  = (state_d == IDLE) ? '0 : ~(COL_ONE << col_idx_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_q <= '1;
      row_sync_q <= '1;
      div_q      <= '0;
      state_q    <= IDLE;
      col_idx_q  <= '0;
      row_idx_q  <= '0;
      deb_q      <= '0;
      rep_q      <= '0;
      key_code_q <= '0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
      release_q  <= 1'b0;
      multi_q    <= 1'b0;
      col_q      <= '0;
    end else begin
      row_meta_q <= row;
      row_sync_q <= row_meta_q;
      div_q      <= div_d;
      state_q    <= state_d;
      col_idx_q  <= col_idx_d;
      row_idx_q  <= row_idx_d;
      deb_q      <= deb_d;
      rep_q      <= rep_d;
      key_code_q <= key_code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
      release_q  <= release_d;
      multi_q    <= multi_d;
      col_q      <= col_d;
    end
  end

  assign col         = col_q;
  assign key_code    = key_code_q;
  assign key_valid   = valid_q;
  assign key_held    = held_q;
  assign key_release = release_q;
  assign multi_key   = multi_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl: a 4x4 switch-matrix model drives two scanners,
// one without and one with auto-repeat, and each step checks hand-computed tick timing.
module tb_keypad_scan_ctrl;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int TD   = 4;
  localparam int DB   = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] keys_a, keys_b;
  logic [3:0]  row_a, row_b, col_a, col_b, code_a, code_b;
  logic        valid_a, held_a, rel_a, multi_a;
  logic        valid_b, held_b, rel_b, multi_b;
  logic [1:0]  ph;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid_a = 0, n_rel_a = 0, n_multi_a = 0;
  int n_valid_b = 0, n_rel_b = 0, n_multi_b = 0;
  int n_overlap = 0;
  int v0, r0, m0;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TD), .DEBOUNCE_TICKS(DB),
                     .REPEAT_TICKS(0)) dut (
    .clk(clk), .rst_n(rst_n), .row(row_a), .col(col_a), .key_code(code_a),
    .key_valid(valid_a), .key_held(held_a), .key_release(rel_a), .multi_key(multi_a));

  keypad_scan_ctrl #(.ROWS(ROWS), .COLS(COLS), .TICK_DIV(TD), .DEBOUNCE_TICKS(DB),
                     .REPEAT_TICKS(5)) dut_rep (
    .clk(clk), .rst_n(rst_n), .row(row_b), .col(col_b), .key_code(code_b),
    .key_valid(valid_b), .key_held(held_b), .key_release(rel_b), .multi_key(multi_b));

  // A pressed switch pulls its row low only while its column is driven low.
  always_comb begin
    row_a = '1;
    row_b = '1;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (keys_a[r*COLS+c] && !col_a[c]) row_a[r] = 1'b0;
        if (keys_b[r*COLS+c] && !col_b[c]) row_b[r] = 1'b0;
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ph <= 2'd0;
    else        ph <= ph + 2'd1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      n_valid_a += int'(valid_a);
      n_rel_a   += int'(rel_a);
      n_multi_a += int'(multi_a);
      n_valid_b += int'(valid_b);
      n_rel_b   += int'(rel_b);
      n_multi_b += int'(multi_b);
      if (int'(valid_a) + int'(rel_a) + int'(multi_a) > 1) n_overlap++;
      if (int'(valid_b) + int'(rel_b) + int'(multi_b) > 1) n_overlap++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] ka, input logic [15:0] kb);
    keys_a = ka;
    keys_b = kb;
  endtask

  // Returns just after the n-th upcoming tick edge, away from any clock edge.
  task automatic waitTicks(input int n);
    for (int i = 0; i < n; i++) begin
      while (ph != 2'd3) @(negedge clk);
      @(negedge clk);
    end
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(16'h0000, 16'h0000);
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_col",     32'(col_a),   32'h0);
    checkOutput("reset_code",    32'(code_a),  32'h0);
    checkOutput("reset_valid",   32'(valid_a), 32'h0);
    checkOutput("reset_held",    32'(held_a),  32'h0);
    checkOutput("reset_release", 32'(rel_a),   32'h0);
    checkOutput("reset_multi",   32'(multi_a), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    waitTicks(2);

    $display("[TB] clean press of key 6");
    v0 = n_valid_a;
    applyStimulus(16'h0040, 16'h0000);
    waitTicks(1);
    checkOutput("scan_col0", 32'(col_a), 32'hE);
    waitTicks(4);
    checkOutput("press_not_yet", 32'(n_valid_a - v0), 32'd0);
    checkOutput("press_held_early", 32'(held_a), 32'h0);
    waitTicks(1);
    checkOutput("press_valid", 32'(valid_a), 32'h1);
    checkOutput("press_code",  32'(code_a),  32'd6);
    checkOutput("press_held",  32'(held_a),  32'h1);
    waitTicks(19);
    checkOutput("press_one_valid", 32'(n_valid_a - v0), 32'd1);
    checkOutput("press_col_held",  32'(col_a), 32'hB);
    r0 = n_rel_a;
    applyStimulus(16'h0000, 16'h0000);
    waitTicks(2);
    checkOutput("release_early", 32'(n_rel_a - r0), 32'd0);
    checkOutput("release_held_early", 32'(held_a), 32'h1);
    waitTicks(1);
    checkOutput("release_strobe", 32'(rel_a), 32'h1);
    checkOutput("release_held", 32'(held_a), 32'h0);
    checkOutput("release_col_idle", 32'(col_a), 32'h0);
    checkOutput("release_code_kept", 32'(code_a), 32'd6);

    $display("[TB] bounce on key 9");
    v0 = n_valid_a;
    applyStimulus(16'h0200, 16'h0000);
    waitTicks(4);
    applyStimulus(16'h0000, 16'h0000);
    waitTicks(4);
    checkOutput("bounce_no_valid", 32'(n_valid_a - v0), 32'd0);
    checkOutput("bounce_code", 32'(code_a), 32'd6);
    checkOutput("bounce_held", 32'(held_a), 32'h0);
    checkOutput("bounce_col_idle", 32'(col_a), 32'h0);

    $display("[TB] two rows on column 1");
    v0 = n_valid_a;
    m0 = n_multi_a;
    applyStimulus(16'h2002, 16'h0000);
    waitTicks(3);
    checkOutput("multi_strobe", 32'(multi_a), 32'h1);
    checkOutput("multi_col_idle", 32'(col_a), 32'h0);
    applyStimulus(16'h0000, 16'h0000);
    waitTicks(4);
    checkOutput("multi_count", 32'(n_multi_a - m0), 32'd1);
    checkOutput("multi_no_valid", 32'(n_valid_a - v0), 32'd0);
    checkOutput("multi_code", 32'(code_a), 32'd6);

    $display("[TB] release glitch on key 5");
    v0 = n_valid_a;
    r0 = n_rel_a;
    applyStimulus(16'h0020, 16'h0000);
    waitTicks(5);
    checkOutput("glitch_accept", 32'(valid_a), 32'h1);
    checkOutput("glitch_code", 32'(code_a), 32'd5);
    waitTicks(2);
    applyStimulus(16'h0000, 16'h0000);
    waitTicks(1);
    applyStimulus(16'h0020, 16'h0000);
    waitTicks(6);
    checkOutput("glitch_held", 32'(held_a), 32'h1);
    checkOutput("glitch_no_release", 32'(n_rel_a - r0), 32'd0);
    checkOutput("glitch_one_valid", 32'(n_valid_a - v0), 32'd1);
    applyStimulus(16'h0000, 16'h0000);
    waitTicks(3);
    checkOutput("glitch_final_release", 32'(rel_a), 32'h1);

    $display("[TB] auto-repeat on key 15");
    v0 = n_valid_b;
    applyStimulus(16'h0000, 16'h8000);
    waitTicks(7);
    checkOutput("repeat_accept", 32'(valid_b), 32'h1);
    checkOutput("repeat_code", 32'(code_b), 32'd15);
    waitTicks(5);
    checkOutput("repeat_first", 32'(valid_b), 32'h1);
    waitTicks(18);
    checkOutput("repeat_count", 32'(n_valid_b - v0), 32'd5);
    checkOutput("repeat_held", 32'(held_b), 32'h1);
    r0 = n_rel_b;
    applyStimulus(16'h0000, 16'h0000);
    waitTicks(3);
    checkOutput("repeat_release", 32'(rel_b), 32'h1);
    checkOutput("repeat_no_extra", 32'(n_valid_b - v0), 32'd5);
    checkOutput("repeat_code_kept", 32'(code_b), 32'd15);

    $display("[TB] reset during debounce of key 6");
    applyStimulus(16'h0040, 16'h0000);
    waitTicks(5);
    checkOutput("deb_not_held", 32'(held_a), 32'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_reset_col", 32'(col_a), 32'h0);
    checkOutput("mid_reset_code", 32'(code_a), 32'h0);
    checkOutput("mid_reset_held", 32'(held_a), 32'h0);
    checkOutput("mid_reset_strobes", 32'({valid_a, rel_a, multi_a}), 32'h0);
    applyStimulus(16'h0000, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    v0 = n_valid_a;
    waitTicks(8);
    checkOutput("post_reset_quiet", 32'(n_valid_a - v0), 32'd0);
    checkOutput("post_reset_code", 32'(code_a), 32'h0);

    checkOutput("strobes_exclusive", 32'(n_overlap), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
